// File: rtl/add_seq_pkg.sv
// Shared types and widths for the two-operand add sequencer.
package add_seq_pkg;
  localparam int OPW  = 8;
  localparam int SUMW = 9;

  typedef enum logic [1:0] {IDLE, LOAD_B, SETTLE, DONE} state_t;
endpackage

// File: rtl/add8_core.sv
// Combinational 8-bit ripple-carry adder; s[8] is the carry out.
module add8_core
  import add_seq_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [SUMW-1:0] s
);
  logic [OPW:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < OPW; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign s[OPW] = c[OPW];
endmodule

// File: rtl/add_sequencer.sv
// Collects operand bytes A then B, lets the adder settle, and hands out A+B.
// Build option ADD_SEQ_OVF_EN adds the signed-overflow output out_ovf.
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SUMW-1:0] out_sum,
  output logic            out_valid,
  input  logic            out_ready
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic            out_ovf
`endif
);
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t          state;
  logic [OPW-1:0]  a_q, b_q;
  logic [3:0]      cnt;
  logic [SUMW-1:0] core_s;

  add8_core u_core (
    .a (a_q),
    .b (b_q),
    .s (core_s)
  );

`ifdef ADD_SEQ_OVF_EN
  logic ovf_next;
  assign ovf_next = (a_q[OPW-1] == b_q[OPW-1]) && (core_s[OPW-1] != a_q[OPW-1]);
`endif

  // in_ready and out_valid are registered alongside the state so they
  // come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef ADD_SEQ_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= in_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_valid && in_ready) begin
            b_q      <= in_data;
            cnt      <= CNT_LOAD;
            in_ready <= 1'b0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            out_sum   <= core_s;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ADD_SEQ_OVF_EN
            out_ovf   <= ovf_next;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_add_sequencer.sv
// Directed self-checking bench for add_sequencer (default SETTLE_CYCLES).
module tb_add_sequencer;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] out_sum;
  logic       out_valid;
  logic       out_ready;
`ifdef ADD_SEQ_OVF_EN
  logic       out_ovf;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int v_cyc = 0;

  add_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ADD_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_pair(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input int gap, input logic [8:0] es, input logic eo);
    int n;
    send(a);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL %s gap: in_ready=%b out_valid=%b required 1/0", nm, in_ready, out_valid);
      else pass_cnt++;
    end
    send(b);
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL %s settle: in_ready=%b out_valid=%b required 0/0", nm, in_ready, out_valid);
    else pass_cnt++;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
    end
    total_cnt++;
    if (n != S) $display("FAIL %s latency: %0d edges after B, required %0d", nm, n, S);
    else pass_cnt++;
    v_cyc = cyc;
    total_cnt++;
    if (out_sum !== es) $display("FAIL %s sum: got %h required %h", nm, out_sum, es);
    else pass_cnt++;
`ifdef ADD_SEQ_OVF_EN
    total_cnt++;
    if (out_ovf !== eo) $display("FAIL %s ovf: got %b required %b", nm, out_ovf, eo);
    else pass_cnt++;
`else
    if (eo === 1'bx) $display("note: unexpected x overflow expectation");
`endif
    if (out_ready) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL %s consume: out_valid=%b in_ready=%b required 0/1", nm, out_valid, in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 9'h000)
      $display("FAIL reset: in_ready=%b out_valid=%b out_sum=%h required 1/0/000",
               in_ready, out_valid, out_sum);
    else pass_cnt++;
`ifdef ADD_SEQ_OVF_EN
    total_cnt++;
    if (out_ovf !== 1'b0) $display("FAIL reset_ovf: got %b required 0", out_ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    run_pair("ad_39", 8'hAD, 8'h39, 0, 9'h0E6, 1'b0);
    run_pair("ff_ff", 8'hFF, 8'hFF, 0, 9'h1FE, 1'b0);
    run_pair("7f_01", 8'h7F, 8'h01, 0, 9'h080, 1'b1);
    run_pair("80_80", 8'h80, 8'h80, 0, 9'h100, 1'b1);
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    run_pair("stall", 8'h12, 8'h34, 0, 9'h046, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h55;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || out_sum !== 9'h046 || in_ready !== 1'b0)
        $display("FAIL stall_hold: out_valid=%b out_sum=%h in_ready=%b required 1/046/0",
                 out_valid, out_sum, in_ready);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else pass_cnt++;
    run_pair("after_stall", 8'h01, 8'h80, 0, 9'h081, 1'b0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'h40);
    send(8'h50);
    in_valid = 1'b1; in_data = 8'h77;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_sum !== 9'h000 || in_ready !== 1'b1)
      $display("FAIL reset_mid: out_valid=%b out_sum=%h in_ready=%b required 0/000/1",
               out_valid, out_sum, in_ready);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_mid_quiet: out_valid=%b required 0", out_valid);
      else pass_cnt++;
    end
    run_pair("post_reset", 8'h01, 8'h02, 0, 9'h003, 1'b0);
  endtask

  task automatic test_gap();
    out_ready = 1'b1;
    run_pair("gap", 8'h10, 8'h20, 4, 9'h030, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    out_ready = 1'b1;
    run_pair("b2b_0", 8'h01, 8'h01, 0, 9'h002, 1'b0);
    t0 = v_cyc;
    run_pair("b2b_1", 8'hC0, 8'hC0, 0, 9'h180, 1'b0);
    t1 = v_cyc;
    run_pair("b2b_2", 8'h64, 8'h64, 0, 9'h0C8, 1'b1);
    t2 = v_cyc;
    total_cnt++;
    if (t1 - t0 != S + 3 || t2 - t1 != S + 3)
      $display("FAIL b2b_rate: spacing %0d,%0d required %0d", t1 - t0, t2 - t1, S + 3);
    else pass_cnt++;
  endtask

  initial begin
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_gap();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles the adder core is held before the sum is captured (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_data  input  8  operand byte; first accepted byte is A, second is B.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port out_sum  output  9  unsigned sum A+B, bit 8 = carry out.
REQ-008 SHALL have port out_valid  output  1  out_sum holds a result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_sum this cycle.
REQ-010 SHALL have port out_ovf  output  1  signed (two's-complement) overflow of A+B; present only with ADD_SEQ_OVF_EN.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD_B, SETTLE, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&in_ready capture in_data into A register, go LOAD_B.
REQ-013 LOAD_B: in_ready=1; on handshake capture in_data into B register, load settle counter with SETTLE_CYCLES-1, go SETTLE.
REQ-014 SETTLE: in_ready=0; counter decrements each cycle; at counter 0, capture core sum into out_sum (and overflow into out_ovf), go DONE.
REQ-015 Operand-to-out_valid latency SHALL be exactly SETTLE_CYCLES+1 cycles after the B handshake cycle.
REQ-016 DONE: out_valid=1, in_ready=0; out_sum and out_ovf stable until out_valid&out_ready; on that handshake go IDLE.
REQ-017 in_ready SHALL be 0 in SETTLE and DONE; in_data with in_valid high in those states SHALL be ignored, not buffered.
REQ-018 in_valid low in IDLE/LOAD_B SHALL hold state indefinitely; a captured A SHALL be kept while waiting for B.
REQ-019 Sum SHALL be 9-bit zero-extended unsigned addition; no saturation; 0xFF+0xFF = 0x1FE.
REQ-020 out_ovf SHALL be 1 iff A[7]==B[7] and sum[7]!=A[7].
REQ-021 Back-to-back: the cycle after the DONE handshake, IDLE SHALL accept a new A (no extra bubble beyond one IDLE cycle).

Reset
REQ-022 rst_n low at a clock edge SHALL force state IDLE, A=B=0, counter=0, out_sum=0, out_valid=0, out_ovf=0; in_ready=1 after the edge.
REQ-023 Reset asserted mid-operation (any state) SHALL discard operands and any pending result; no out_valid after release until a full new A,B pair.
REQ-024 Reset SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-025 Macro ADD_SEQ_OVF_EN defined: out_ovf port and its register SHALL exist per REQ-020.
REQ-026 Macro ADD_SEQ_OVF_EN undefined: out_ovf port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package add_seq_pkg SHALL hold the state enum (IDLE, LOAD_B, SETTLE, DONE), OPW=8, SUMW=9 constants.
REQ-028 Addition SHALL be done in one sub-module add8_core (combinational 8-bit ripple adder, inputs a,b, outputs s[8:0]), fed directly from A/B registers.
REQ-029 Sequential logic SHALL reside only in add_sequencer.

Verification
REQ-030 A=0xAD, B=0x39, SETTLE_CYCLES=2, out_ready=1 -> out_sum=0x0E6, out_valid high 3 cycles after B handshake for 1 cycle, out_ovf=0.
REQ-031 A=0xFF, B=0xFF -> out_sum=0x1FE, out_ovf=0; A=0x7F, B=0x01 -> out_sum=0x080, out_ovf=1.
REQ-032 out_ready held 0 for 5 cycles in DONE, in_valid pulsed with 0x55 -> out_sum stable, in_ready=0, byte ignored; next pair sums correctly.
REQ-033 rst_n low 1 cycle while in SETTLE -> out_valid stays 0, out_sum=0, next pair 0x01,0x02 -> 0x003.
REQ-034 in_valid gap of 4 cycles between A=0x10 and B=0x20 -> out_sum=0x030; back-to-back pairs with out_ready=1 -> one result per SETTLE_CYCLES+3 cycles.
